// File: rtl/delay_meas_pkg.sv
// Shared types and constants for the trigger-to-response delay meter.
package delay_meas_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold
    } state_e;

    localparam int unsigned CntWDefault   = 16;
    localparam int unsigned SyncStagesMin = 2;

endpackage

// File: rtl/delay_meter_if.sv
// Result handshake between the delay meter (master) and the control logic (slave).
interface delay_meter_if #(
    parameter int unsigned CNT_W = delay_meas_pkg::CntWDefault
);

    logic [CNT_W-1:0] meas;
    logic             meas_valid;
    logic             meas_ready;
    logic             timeout;

    modport master(output meas, output meas_valid, output timeout, input meas_ready);
    modport slave(input meas, input meas_valid, input timeout, output meas_ready);

endinterface

// File: rtl/sync_rise_detect.sv
// Synchronises an asynchronous level and flags its rising edge for one cycle.
module sync_rise_detect
    import delay_meas_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SyncStagesMin
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stop_d;

    if (SYNC_STAGES < SyncStagesMin) begin : g_bad_stages
        $error("sync_rise_detect: SYNC_STAGES below minimum");
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync   <= '0;
            r_stop_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_stop_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_stop_d;

endmodule

// File: rtl/delay_meter.sv
// Counts cycles from an accepted start pulse to the synchronised rising edge of stop_in,
// with a timeout bound, and hands the result over a valid/ready interface.
module delay_meter
    import delay_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned SYNC_STAGES = SyncStagesMin
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop_in,
    delay_meter_if.master        bus,
    output logic                 busy,
    output logic                 start_dropped
);

    // The counter cannot wrap because the limit always fits in CNT_W bits.
    if (MAX_CYCLES < 1 || (CNT_W < 32 && MAX_CYCLES > (32'd1 << CNT_W) - 32'd1)) begin : g_bad_max
        $error("delay_meter: MAX_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CYCLES);

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
    logic [CNT_W-1:0] r_meas, w_meas_d;
    logic             r_valid, w_valid_d;
    logic             r_timeout, w_timeout_d;
    logic             r_dropped, w_dropped_d;
    logic             w_rise;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_stop_edge (
        .clk    (clk),
        .reset  (reset),
        .i_async(stop_in),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_meas    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_meas    <= w_meas_d;
            r_valid   <= w_valid_d;
            r_timeout <= w_timeout_d;
            r_dropped <= w_dropped_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_meas_d    = r_meas;
        w_valid_d   = r_valid;
        w_timeout_d = r_timeout;
        w_cnt_inc   = r_cnt + CNT_W'(1);
        w_dropped_d = start && (r_state != StIdle);
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_cnt_d   = '0;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                // A rise on the limit edge still counts as a real response.
                if (w_rise) begin
                    w_meas_d    = w_cnt_inc;
                    w_timeout_d = 1'b0;
                    w_valid_d   = 1'b1;
                    w_state_d   = StHold;
                end else if (w_cnt_inc == MaxCnt) begin
                    w_meas_d    = MaxCnt;
                    w_timeout_d = 1'b1;
                    w_valid_d   = 1'b1;
                    w_state_d   = StHold;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            StHold: begin
                if (r_valid && bus.meas_ready) begin
                    w_valid_d = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign busy           = (r_state != StIdle);
    assign start_dropped  = r_dropped;
    assign bus.meas       = r_meas;
    assign bus.meas_valid = r_valid;
    assign bus.timeout    = r_timeout;

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter with an edge-history reference model checked every cycle.
module tb_delay_meter;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned MAXC  = 20;
    localparam int unsigned SYNC  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic stop_in = 1'b0;
    logic busy;
    logic start_dropped;

    delay_meter_if #(.CNT_W(CNT_W)) bus ();

    delay_meter #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAXC),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop_in      (stop_in),
        .bus          (bus),
        .busy         (busy),
        .start_dropped(start_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: stop_in sampled before each edge; a rise is seen at edge m when the
    // sample SYNC edges earlier is 1 and the one before it is 0. Samples older than the
    // last reset read as 0.
    bit hist[int];
    int edge_n = 0;
    int valid_from = 1;
    int m_mode = 0;  // 0 idle, 1 waiting, 2 holding
    int m_k = 0;
    int m_meas = 0;
    int m_to = 0;
    int m_valid = 0;
    int m_drop = 0;

    function automatic int samp(input int i);
        if (i >= valid_from && hist.exists(i)) return int'(hist[i]);
        return 0;
    endfunction

    task automatic model_clear();
        m_mode = 0; m_meas = 0; m_to = 0; m_valid = 0; m_drop = 0;
        valid_from = edge_n + 1;
    endtask

    task automatic model_edge();
        int el;
        bit rise;
        edge_n++;
        hist[edge_n] = stop_in;
        rise = (samp(edge_n - SYNC) == 1) && (samp(edge_n - SYNC - 1) == 0);
        m_drop = (start && m_mode != 0) ? 1 : 0;
        case (m_mode)
            0: if (start) begin m_k = edge_n; m_mode = 1; end
            1: begin
                el = edge_n - m_k;
                if (rise) begin
                    m_meas = el; m_to = 0; m_valid = 1; m_mode = 2;
                end else if (el == MAXC) begin
                    m_meas = MAXC; m_to = 1; m_valid = 1; m_mode = 2;
                end
            end
            default: if (bus.meas_ready) begin m_valid = 0; m_mode = 0; end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc.meas", int'(bus.meas), m_meas);
            chk("cyc.valid", int'(bus.meas_valid), m_valid);
            chk("cyc.timeout", int'(bus.timeout), m_to);
            chk("cyc.busy", int'(busy), (m_mode != 0) ? 1 : 0);
            chk("cyc.dropped", int'(start_dropped), m_drop);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic chk_result(input string name, input int v, input int m, input int t);
        chk({name, ".valid"}, int'(bus.meas_valid), v);
        chk({name, ".meas"}, int'(bus.meas), m);
        chk({name, ".timeout"}, int'(bus.timeout), t);
    endtask

    initial begin
        bus.meas_ready = 1'b1;
        step(3);
        chk_result("reset", 0, 0, 0);
        chk("reset.busy", int'(busy), 0);
        reset = 1'b1;
        step(2);

        // Nominal: stop high before edge k+11 -> 13
        pulse_start();
        step(10);
        stop_in = 1'b1;
        step(2);
        chk("nom.busy", int'(busy), 1);
        step(1);
        chk_result("nom", 1, 13, 0);
        step(1);
        chk("nom.idle", int'(busy), 0);
        stop_in = 1'b0;
        step(4);

        // Timeout with stop held low
        pulse_start();
        step(19);
        chk("to.early", int'(bus.meas_valid), 0);
        step(1);
        chk_result("to", 1, 20, 1);
        step(3);

        // Rise coincides with the limit edge
        pulse_start();
        step(17);
        stop_in = 1'b1;
        step(3);
        chk_result("coin", 1, 20, 0);
        step(1);
        stop_in = 1'b0;
        step(4);

        // Backpressure and a start dropped during HOLD
        bus.meas_ready = 1'b0;
        pulse_start();
        step(4);
        stop_in = 1'b1;
        step(3);
        chk_result("bp", 1, 7, 0);
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("bp.drop", int'(start_dropped), 1);
        step(1);
        chk("bp.drop_end", int'(start_dropped), 0);
        chk_result("bp.held", 1, 7, 0);
        step(1);
        bus.meas_ready = 1'b1;
        step(1);
        chk("bp.busy", int'(busy), 0);
        chk_result("bp.done", 0, 7, 0);
        stop_in = 1'b0;
        step(4);

        // Stop already high at start is not a rise
        stop_in = 1'b1;
        step(3);
        pulse_start();
        step(20);
        chk_result("prehigh", 1, 20, 1);
        stop_in = 1'b0;
        step(3);
        pulse_start();
        step(2);
        stop_in = 1'b1;
        step(3);
        chk_result("prehigh.re", 1, 5, 0);
        step(1);
        stop_in = 1'b0;
        step(3);

        // Reset in the middle of WAIT
        pulse_start();
        step(5);
        reset = 1'b0;
        #1;
        chk_result("rst", 0, 0, 0);
        chk("rst.busy", int'(busy), 0);
        step(2);
        reset = 1'b1;
        stop_in = 1'b1;
        step(10);
        chk("rst.novalid", int'(bus.meas_valid), 0);
        stop_in = 1'b0;
        step(3);
        pulse_start();
        step(1);
        stop_in = 1'b1;
        step(3);
        chk_result("rst.after", 1, 4, 0);
        step(1);

        // Back-to-back: start on the edge after the handshake
        stop_in = 1'b0;
        step(3);
        pulse_start();
        step(1);
        stop_in = 1'b1;
        step(3);
        chk_result("b2b.first", 1, 4, 0);
        step(1);
        pulse_start();
        chk("b2b.busy", int'(busy), 1);
        stop_in = 1'b0;
        step(2);
        stop_in = 1'b1;
        step(3);
        chk_result("b2b.second", 1, 5, 0);
        step(1);

        // Start on the handshake edge itself is dropped
        stop_in = 1'b0;
        step(3);
        pulse_start();
        step(1);
        stop_in = 1'b1;
        step(3);
        chk_result("hs.res", 1, 4, 0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("hs.drop", int'(start_dropped), 1);
        chk("hs.busy", int'(busy), 0);
        step(1);
        chk("hs.nostart", int'(busy), 0);
        step(5);
        chk("hs.still_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
